// File: rtl/pong_pkg.sv
// +--------------------------------------------------------------------+
// | pong_pkg : shared playfield geometry and step-period helper         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package pong_pkg;
  localparam int SCREEN_W    = 32;
  localparam int ROW_MAX     = SCREEN_W - 1;
  localparam int CENTER      = 16;
  localparam int LEFT_COL    = 0;
  localparam int RIGHT_COL   = 31;
  localparam int PERIOD_UNIT = 8;

  typedef logic [4:0] coord_t;

  // Last counter value of a step period: (16 - speed) * PERIOD_UNIT - 1.
  function automatic logic [6:0] period_last(input logic [3:0] speed);
    logic [7:0] p;
    p = (8'd16 - {4'd0, speed}) * 8'(PERIOD_UNIT);
    return 7'(p - 8'd1);
  endfunction
endpackage

`default_nettype wire

// File: rtl/pong_ball_step_timer.sv
// +--------------------------------------------------------------------+
// | step_timer : speed-scaled counter emitting one-cycle step pulses    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module step_timer
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] speed,
  input  logic       clear,
  input  logic       hold,
  output logic       step
);

  logic [6:0] cnt_q;
  logic [6:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (clear || hold || speed == 4'd0) begin
      cnt_d = 7'd0;
    end else if (cnt_q >= period_last(speed)) begin
      // >= so that lowering the period mid-count fires at once
      step  = 1'b1;
      cnt_d = 7'd0;
    end else begin
      cnt_d = cnt_q + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 7'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/pong_ball.sv
// +--------------------------------------------------------------------+
// | pong_ball : ball position/direction engine with wall/paddle bounce  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module pong_ball
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ball_reset,
  input  logic [4:0]  entropy,
  input  logic [3:0]  speed,
  input  logic [31:0] lpaddle,
  input  logic [31:0] rpaddle,
  output logic [4:0]  x,
  output logic [4:0]  y,
  output logic        out_left,
  output logic        out_right
);

  coord_t x_q, x_d, y_q, y_d, ny;
  logic   dx_q, dx_d, dy_q, dy_d;
  logic   out_left_q, out_left_d, out_right_q, out_right_d;
  logic   step;

  step_timer u_step_timer (
    .clk   (clk),
    .reset (reset),
    .speed (speed),
    .clear (ball_reset),
    .hold  (out_left_q | out_right_q),
    .step  (step)
  );

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    ny          = dy_q ? y_q + 5'd1 : y_q - 5'd1;

    if (ball_reset) begin
      x_d         = coord_t'(CENTER);
      y_d         = coord_t'(CENTER);
      dx_d        = entropy[0];
      dy_d        = entropy[1];
      out_left_d  = 1'b0;
      out_right_d = 1'b0;
    end else if (step) begin
      if (dy_q && y_q == coord_t'(ROW_MAX)) begin
        dy_d = 1'b0;
        ny   = coord_t'(ROW_MAX - 1);
      end else if (!dy_q && y_q == 5'd0) begin
        dy_d = 1'b1;
        ny   = 5'd1;
      end
      y_d = ny;

      // Paddle decisions look at the row the ball is moving into
      if (!dx_q) begin
        if (x_q == coord_t'(LEFT_COL + 1)) begin
          if (lpaddle[ny]) begin
            dx_d = 1'b1;
            x_d  = coord_t'(LEFT_COL + 2);
          end else begin
            x_d        = coord_t'(LEFT_COL);
            out_left_d = 1'b1;
          end
        end else begin
          x_d = x_q - 5'd1;
        end
      end else begin
        if (x_q == coord_t'(RIGHT_COL - 1)) begin
          if (rpaddle[ny]) begin
            dx_d = 1'b0;
            x_d  = coord_t'(RIGHT_COL - 2);
          end else begin
            x_d         = coord_t'(RIGHT_COL);
            out_right_d = 1'b1;
          end
        end else begin
          x_d = x_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= coord_t'(CENTER);
      y_q         <= coord_t'(CENTER);
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      out_left_q  <= 1'b0;
      out_right_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign out_left  = out_left_q;
  assign out_right = out_right_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_ball.sv
// +--------------------------------------------------------------------+
// | tb_pong_ball : directed self-checking bench for pong_ball           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pong_ball;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ball_reset = 1'b0;
  logic [4:0]  entropy = 5'd0;
  logic [3:0]  speed = 4'd0;
  logic [31:0] lpaddle = 32'd0;
  logic [31:0] rpaddle = 32'd0;
  logic [4:0]  x, y;
  logic        out_left, out_right;

  int checks = 0;
  int failures = 0;

  pong_ball dut (
    .clk        (clk),
    .reset      (reset),
    .ball_reset (ball_reset),
    .entropy    (entropy),
    .speed      (speed),
    .lpaddle    (lpaddle),
    .rpaddle    (rpaddle),
    .x          (x),
    .y          (y),
    .out_left   (out_left),
    .out_right  (out_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [1:0] ent);
    entropy    = {3'd0, ent};
    ball_reset = 1'b1;
    tick(1);
    ball_reset = 1'b0;
  endtask

  initial begin
    // Reset and frozen at speed 0
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_x", x, 16);
    check("rst_y", y, 16);
    check("rst_out_left", out_left, 0);
    check("rst_out_right", out_right, 0);
    tick(500);
    check("spd0_x", x, 16);
    check("spd0_y", y, 16);

    // Serve down-right at full speed, step every 8 clocks
    speed   = 4'd15;
    rpaddle = 32'hFFFF_FFFF;
    serve(2'b11);
    check("serve_x", x, 16);
    tick(7);
    check("pre_step_x", x, 16);
    tick(1);
    check("step1_x", x, 17);
    check("step1_y", y, 17);
    tick(8);
    check("step2_x", x, 18);
    check("step2_y", y, 18);

    // Run to (30,30); next step hits right paddle and bottom wall area
    tick(8 * 12);
    check("pre_wall_x", x, 30);
    check("pre_wall_y", y, 30);
    tick(8);
    check("wall1_x", x, 29);
    check("wall1_y", y, 31);
    tick(8);
    check("wall2_x", x, 28);
    check("wall2_y", y, 30);
    tick(8);
    check("wall3_x", x, 27);
    check("wall3_y", y, 29);
    check("wall_out_right", out_right, 0);

    // Left paddle hit combined with top-wall approach
    lpaddle = 32'hFFFF_FFFF;
    serve(2'b00);
    tick(8 * 15);
    check("lhit_pre_x", x, 1);
    check("lhit_pre_y", y, 1);
    tick(8);
    check("lhit_x", x, 2);
    check("lhit_y", y, 0);
    check("lhit_out_left", out_left, 0);
    tick(8);
    check("lhit_next_x", x, 3);
    check("lhit_next_y", y, 1);

    // Miss: paddle only on row 31, ball bounces off bottom into row 30
    lpaddle = 32'h8000_0000;
    serve(2'b10);
    tick(8 * 15);
    check("miss_pre_x", x, 1);
    check("miss_pre_y", y, 31);
    tick(8);
    check("miss_x", x, 0);
    check("miss_y", y, 30);
    check("miss_out_left", out_left, 1);
    check("miss_out_right", out_right, 0);
    tick(1000);
    check("frozen_x", x, 0);
    check("frozen_y", y, 30);
    check("frozen_out_left", out_left, 1);
    serve(2'b11);
    check("reserve_out_left", out_left, 0);
    check("reserve_x", x, 16);
    check("reserve_y", y, 16);

    // Speed change mid-count: counter already past the new period
    speed = 4'd1;
    serve(2'b11);
    tick(100);
    check("slow_x", x, 16);
    speed = 4'd15;
    tick(1);
    check("fast_x", x, 17);
    check("fast_y", y, 17);

    // Synchronous reset mid-play
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst2_x", x, 16);
    check("rst2_y", y, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
